// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants, FSM encodings and final-block padding helper
// for the Ascon-Hash sequencing controller.
package ascon_pkg;

  localparam int unsigned BW           = 64;
  localparam int unsigned SW           = 5 * BW;
  localparam int unsigned DIGEST_WORDS = 4;
  localparam int unsigned CNT_W        = $clog2(DIGEST_WORDS);
  localparam int unsigned NB_W         = 4;
  localparam int unsigned ST_W         = 3;

  localparam logic [BW-1:0] IV       = 64'h00400C0000000100;
  localparam logic [SW-1:0] IV_STATE = {IV, {(SW-BW){1'b0}}};

  // P12(IV || 0), lets the first permutation be skipped
  localparam logic [SW-1:0] PRECOMP_STATE = {64'hee9398aadb67f03d, 64'h8bb21831c60f1002,
                                             64'hb48a92db98d5da62, 64'h43189921b8f8e3e8,
                                             64'h348fa5c9d525e140};

  localparam logic [BW-1:0] PAD_WORD = 64'h8000000000000000;

  localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [ST_W-1:0] ST_INIT    = 3'd1;
  localparam logic [ST_W-1:0] ST_ABSORB  = 3'd2;
  localparam logic [ST_W-1:0] ST_PERM_A  = 3'd3;
  localparam logic [ST_W-1:0] ST_PAD     = 3'd4;
  localparam logic [ST_W-1:0] ST_PERM_P  = 3'd5;
  localparam logic [ST_W-1:0] ST_SQUEEZE = 3'd6;
  localparam logic [ST_W-1:0] ST_PERM_S  = 3'd7;

  typedef struct packed {
    logic [BW-1:0] mask;
    logic [BW-1:0] pad;
  } pad_info_t;

  // Byte count -> keep-mask for the valid top bytes and the 0x80 pad bit just below them.
  // Counts above 8 saturate; a shift of BW clears everything, giving an all-ones mask and no pad.
  function automatic pad_info_t pad_info(input logic [NB_W-1:0] nbytes);
    pad_info_t       r;
    logic [NB_W-1:0] n;
    n      = (nbytes > NB_W'(8)) ? NB_W'(8) : nbytes;
    r.mask = ~({BW{1'b1}} >> {n, 3'b000});
    r.pad  = PAD_WORD >> {n, 3'b000};
    return r;
  endfunction

endpackage

// File: rtl/ascon_hash_pad.sv
// ascon_hash_pad: combinational masking and pad-bit insertion for a message block.
// Ports:
//   msg_data  in  BW    raw block, first byte in the top byte lane
//   msg_bytes in  NB_W  valid bytes in the final block (values above 8 act as 8)
//   msg_last  in  1     block is the final one
//   blk_c     out BW    value to XOR into x0
//   full_c    out 1     no pad bit went into this block (non-final, or a full final block)
module ascon_hash_pad
  import ascon_pkg::*;
(
  input  logic [BW-1:0]   msg_data,
  input  logic [NB_W-1:0] msg_bytes,
  input  logic            msg_last,
  output logic [BW-1:0]   blk_c,
  output logic            full_c
);

  pad_info_t pinfo;

  always_comb begin
    pinfo  = pad_info(msg_bytes);
    blk_c  = msg_data;
    full_c = 1'b1;
    if (msg_last) begin
      blk_c  = (msg_data & pinfo.mask) | pinfo.pad;
      full_c = (msg_bytes >= NB_W'(8));
    end
  end

endmodule

// File: rtl/ascon_hash_ctrl.sv
// ascon_hash_ctrl: Ascon-Hash sequencing controller. Owns the 320-bit sponge
// state, absorbs padded 64-bit message blocks, launches one external P12 job per
// sponge step and squeezes DIGEST_WORDS x0 words out of a valid/ready stream.
// Build option: define ASCON_HASH_PRECOMP_IV_EN to start from the precomputed
// P12(IV||0) state and skip the initial permutation.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   start / busy                     launch a hash / hash in flight
//   msg_data/valid/last/bytes/ready  message block stream in
//   dig_data/valid/last/ready        digest word stream out
//   p_start/p_state_in               permutation launch and operand (held until p_done)
//   p_state_out/p_done               permutation result
module ascon_hash_ctrl
  import ascon_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  input  logic [BW-1:0]   msg_data,
  input  logic            msg_valid,
  input  logic            msg_last,
  input  logic [NB_W-1:0] msg_bytes,
  output logic            msg_ready,
  output logic [BW-1:0]   dig_data,
  output logic            dig_valid,
  output logic            dig_last,
  input  logic            dig_ready,
  output logic            p_start,
  output logic [SW-1:0]   p_state_in,
  input  logic [SW-1:0]   p_state_out,
  input  logic            p_done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGEST_WORDS - 1);

  logic [ST_W-1:0]  st_q, st_d;
  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d, msg_ready_d, dig_valid_d, dig_last_d, p_start_d;
  logic [BW-1:0]    blk_c;
  logic             full_c;

  ascon_hash_pad u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .msg_last  (msg_last),
    .blk_c     (blk_c),
    .full_c    (full_c)
  );

  // The state register doubles as the permutation operand and the digest word.
  assign p_state_in = state_q;
  assign dig_data   = state_q[SW-1 -: BW];

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= ST_IDLE;
      state_q   <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      msg_ready <= 1'b0;
      dig_valid <= 1'b0;
      dig_last  <= 1'b0;
      p_start   <= 1'b0;
    end else begin
      st_q      <= st_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      msg_ready <= msg_ready_d;
      dig_valid <= dig_valid_d;
      dig_last  <= dig_last_d;
      p_start   <= p_start_d;
    end
  end

  // Next-state and next-output logic; strobes default low, ready/valid re-asserted per state
  always_comb begin
    st_d        = st_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    busy_d      = busy;
    msg_ready_d = 1'b0;
    dig_valid_d = 1'b0;
    dig_last_d  = 1'b0;
    p_start_d   = 1'b0;

    case (st_q)
      ST_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
`ifdef ASCON_HASH_PRECOMP_IV_EN
          state_d     = PRECOMP_STATE;
          msg_ready_d = 1'b1;
          st_d        = ST_ABSORB;
`else
          state_d   = IV_STATE;
          p_start_d = 1'b1;
          st_d      = ST_INIT;
`endif
        end
      end

      ST_INIT, ST_PERM_A: begin
        if (p_done) begin
          state_d     = p_state_out;
          msg_ready_d = 1'b1;
          st_d        = ST_ABSORB;
        end
      end

      ST_ABSORB: begin
        msg_ready_d = 1'b1;
        if (msg_valid && msg_ready) begin
          msg_ready_d            = 1'b0;
          state_d[SW-1 -: BW]    = state_q[SW-1 -: BW] ^ blk_c;
          p_start_d              = 1'b1;
          if (!msg_last)   st_d = ST_PERM_A;
          else if (full_c) st_d = ST_PAD;
          else             st_d = ST_PERM_P;
        end
      end

      // A full final block still needs a separate pad-only block.
      ST_PAD: begin
        if (p_done) begin
          state_d             = p_state_out;
          state_d[SW-1 -: BW] = p_state_out[SW-1 -: BW] ^ PAD_WORD;
          p_start_d           = 1'b1;
          st_d                = ST_PERM_P;
        end
      end

      ST_PERM_P: begin
        if (p_done) begin
          state_d     = p_state_out;
          cnt_d       = '0;
          dig_valid_d = 1'b1;
          dig_last_d  = (LAST_CNT == CNT_W'(0));
          st_d        = ST_SQUEEZE;
        end
      end

      ST_SQUEEZE: begin
        dig_valid_d = 1'b1;
        dig_last_d  = dig_last;
        if (dig_valid && dig_ready) begin
          dig_valid_d = 1'b0;
          dig_last_d  = 1'b0;
          if (dig_last) begin
            busy_d = 1'b0;
            st_d   = ST_IDLE;
          end else begin
            cnt_d     = cnt_q + CNT_W'(1);
            p_start_d = 1'b1;
            st_d      = ST_PERM_S;
          end
        end
      end

      ST_PERM_S: begin
        if (p_done) begin
          state_d     = p_state_out;
          dig_valid_d = 1'b1;
          dig_last_d  = (cnt_q == LAST_CNT);
          st_d        = ST_SQUEEZE;
        end
      end

      default: st_d = ST_IDLE;
    endcase
  end

endmodule
